mem_port_arbiter: RTL

//  Shares one single-ported unified memory between the IF stage (instruction fetch)
//  and the MEM stage (load/store) of the 5-stage mips_processor pipeline.

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// mem_port_arbiter_if : pipeline-side and memory-side bus of the port arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              inst_req;
   logic [ADDR_W-1:0] inst_addr;
   logic              inst_flush;
   logic [DATA_W-1:0] inst_data;
   logic              inst_valid;
   logic              stall_if;
   logic [1:0]        data_read;
   logic [1:0]        data_write;
   logic [ADDR_W-1:0] data_addr;
   logic [DATA_W-1:0] data_wr_data;
   logic [DATA_W-1:0] data_rd_data;
   logic              data_valid;
   logic              stall_mem;
   logic              mem_req;
   logic              mem_we;
   logic [1:0]        mem_size;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ack;
   logic              bus_err;

   // master: the arbiter itself
   modport master (
      input  inst_req, inst_addr, inst_flush, data_read, data_write, data_addr,
             data_wr_data, mem_rdata, mem_ack,
      output inst_data, inst_valid, stall_if, data_rd_data, data_valid, stall_mem,
             mem_req, mem_we, mem_size, mem_addr, mem_wdata, bus_err
   );

   // slave: the pipeline stages plus the memory
   modport slave (
      output inst_req, inst_addr, inst_flush, data_read, data_write, data_addr,
             data_wr_data, mem_rdata, mem_ack,
      input  inst_data, inst_valid, stall_if, data_rd_data, data_valid, stall_mem,
             mem_req, mem_we, mem_size, mem_addr, mem_wdata, bus_err
   );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter : shares one single-port memory between IF fetch and MEM load/store
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_port_arbiter_if.master bus
);

   localparam int c_wdog_w = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_INST = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic                w_data_op;
   logic                w_busy;
   logic                w_timeout;
   logic                w_grant_data;
   logic                w_grant_inst;
   logic                w_data_valid;
   logic                w_inst_valid;

   logic                r_sel_data;
   logic                r_flushed;
   logic                r_we;
   logic                r_bus_err;
   logic [1:0]          r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rbuf;
   logic [DATA_W-1:0]   r_inst_data;
   logic [DATA_W-1:0]   r_data_rd;
   logic [c_wdog_w-1:0] r_wdog;

   assign w_data_op = (|bus.data_read) | (|bus.data_write);
   assign w_busy    = (r_state == S_DATA) || (r_state == S_INST);
   assign w_timeout = (TIMEOUT != 0) && w_busy && !bus.mem_ack &&
                      (r_wdog == c_wdog_w'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_grant_data = 1'b0;
      w_grant_inst = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_data_op) begin
               w_grant_data = 1'b1;
               w_next       = S_DATA;
            end else if (bus.inst_req) begin
               w_grant_inst = 1'b1;
               w_next       = S_INST;
            end
         end
         S_DATA, S_INST: begin
            if (bus.mem_ack || w_timeout) begin
               w_next = S_DONE;
            end
         end
         // No grant here: the finished requester is still asserting its request.
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // A flushed fetch still completes on the bus but never reaches the pipeline.
   assign w_data_valid = (r_state == S_DONE) && r_sel_data;
   assign w_inst_valid = (r_state == S_DONE) && !r_sel_data && !r_flushed && !bus.inst_flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel_data  <= 1'b0;
         r_flushed   <= 1'b0;
         r_we        <= 1'b0;
         r_bus_err   <= 1'b0;
         r_size      <= 2'b00;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rbuf      <= '0;
         r_inst_data <= '0;
         r_data_rd   <= '0;
         r_wdog      <= '0;
      end else begin
         if (w_grant_data) begin
            r_sel_data <= 1'b1;
            r_flushed  <= 1'b0;
            r_addr     <= bus.data_addr;
            r_we       <= |bus.data_write;
            r_size     <= (|bus.data_write) ? bus.data_write : bus.data_read;
            r_wdata    <= bus.data_wr_data;
            r_wdog     <= '0;
         end else if (w_grant_inst) begin
            r_sel_data <= 1'b0;
            r_flushed  <= 1'b0;
            r_addr     <= bus.inst_addr;
            r_we       <= 1'b0;
            r_size     <= 2'b11;
            r_wdog     <= '0;
         end
         if (w_busy) begin
            if (bus.mem_ack) begin
               if (!r_we) begin
                  r_rbuf <= bus.mem_rdata;
               end
            end else if (w_timeout) begin
               r_rbuf    <= '0;
               r_bus_err <= 1'b1;
            end else begin
               r_wdog <= r_wdog + c_wdog_w'(1);
            end
         end
         if (bus.inst_flush && !r_sel_data && ((r_state == S_INST) || (r_state == S_DONE))) begin
            r_flushed <= 1'b1;
         end
         if (w_data_valid && !r_we) begin
            r_data_rd <= r_rbuf;
         end
         if (w_inst_valid) begin
            r_inst_data <= r_rbuf;
         end
      end
   end

   // Result buses show the fresh word during the valid pulse and hold it afterwards.
   assign bus.data_valid   = w_data_valid;
   assign bus.inst_valid   = w_inst_valid;
   assign bus.data_rd_data = (w_data_valid && !r_we) ? r_rbuf : r_data_rd;
   assign bus.inst_data    = w_inst_valid ? r_rbuf : r_inst_data;
   assign bus.stall_mem    = w_data_op & ~w_data_valid;
   assign bus.stall_if     = (bus.inst_req & ~w_inst_valid) | (w_data_op & ~w_data_valid);
   assign bus.mem_req      = w_busy;
   assign bus.mem_we       = r_we;
   assign bus.mem_size     = r_size;
   assign bus.mem_addr     = r_addr;
   assign bus.mem_wdata    = r_wdata;
   assign bus.bus_err      = r_bus_err;

endmodule

`default_nettype wire
